// File: rtl/elevator_pkg.sv
// Shared types for the 4-floor elevator: floor index, request-unit states and
// the motor encodings used by the controller FSM.
package elevator_pkg;

  localparam int NUM_FLOORS = 4;

  typedef logic [1:0] floor_t;

  typedef enum logic [1:0] {
    MOVING  = 2'd0,
    SERVING = 2'd1,
    DONE    = 2'd2
  } serve_state_t;

  typedef enum logic [1:0] {
    MOTOR_STOP = 2'd0,
    MOTOR_UP   = 2'd1,
    MOTOR_DOWN = 2'd2
  } motor_t;

  // Lowest asserted sensor wins, so scan from the top down and let lower bits overwrite.
  function automatic floor_t sensor_to_floor(input logic [NUM_FLOORS-1:0] sensor);
    floor_t f;
    f = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (sensor[i]) f = floor_t'(i);
    end
    return f;
  endfunction

endpackage

// File: rtl/door_timer.sv
// Door-open interval counter: loads RELOAD, counts down while enabled and
// flags expiry at zero.
module door_timer #(
  parameter logic [3:0] RELOAD = 4'd7
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);

  logic [3:0] count;

  // Load has priority so a re-open during the countdown restarts the full interval.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (enable && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign expired = (count == 4'd0);

endmodule

// File: rtl/call_request_unit.sv
// Request front end for the 4-floor elevator: holds button requests, tracks the
// floor, clears requests while serving a stop and drives the door-hold interval.
module call_request_unit
  import elevator_pkg::*;
#(
  parameter int DOOR_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sensor,
  input  logic [3:0] hall_up,
  input  logic [3:0] hall_dn,
  input  logic [3:0] cab,
  input  logic       stop,
  output logic [3:0] up_req,
  output logic [3:0] dn_req,
  output logic [3:0] cab_req,
  output floor_t     floor,
  output logic       door_hold,
  output logic       req_above,
  output logic       req_below,
  output logic       any_req
);

  serve_state_t state, next_state;
  floor_t       sensor_floor;
  logic         at_floor;
  logic         floor_button;
  logic         serve_load;
  logic         expired;
  logic [3:0]   up_btn, dn_btn;
  logic [3:0]   clr_mask;
  logic [3:0]   all_req;
  logic [3:0]   above_mask, below_mask;

  // No up button exists on the top floor and no down button on the ground floor.
  assign up_btn       = hall_up & 4'b0111;
  assign dn_btn       = hall_dn & 4'b1110;
  assign at_floor     = |sensor;
  assign sensor_floor = sensor_to_floor(sensor);
  assign floor_button = up_btn[sensor_floor] | dn_btn[sensor_floor] | cab[sensor_floor];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MOVING;
    end else begin
      state <= next_state;
    end
  end

  // serve_load marks every edge that (re)opens the door: it clears the floor's
  // requests and restarts the timer.
  always_comb begin
    next_state = state;
    serve_load = 1'b0;
    case (state)
      MOVING: begin
        if (stop && at_floor) begin
          next_state = SERVING;
          serve_load = 1'b1;
        end
      end
      SERVING: begin
        if (at_floor && floor_button) begin
          serve_load = 1'b1;
        end else if (expired) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (!stop || !at_floor) begin
          next_state = MOVING;
        end else if (floor_button) begin
          next_state = SERVING;
          serve_load = 1'b1;
        end
      end
      default: next_state = MOVING;
    endcase
  end

  door_timer #(
    .RELOAD(4'(DOOR_CYCLES - 1))
  ) u_door_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (serve_load),
    .enable (state == SERVING),
    .expired(expired)
  );

  assign clr_mask = serve_load ? (4'b0001 << sensor_floor) : 4'b0000;

  // Clear is applied after the set so a press on the serving edge stays cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_req  <= '0;
      dn_req  <= '0;
      cab_req <= '0;
      floor   <= '0;
    end else begin
      up_req  <= (up_req | up_btn) & ~clr_mask;
      dn_req  <= (dn_req | dn_btn) & ~clr_mask;
      cab_req <= (cab_req | cab) & ~clr_mask;
      if (at_floor) floor <= sensor_floor;
    end
  end

  assign door_hold = (state == SERVING);
  assign all_req   = up_req | dn_req | cab_req;

  always_comb begin
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_mask[i] = (i > int'(floor));
      below_mask[i] = (i < int'(floor));
    end
  end

  assign req_above = |(all_req & above_mask);
  assign req_below = |(all_req & below_mask);
  assign any_req   = |all_req;

endmodule

// File: tb/tb_call_request_unit.sv
// Directed bench for call_request_unit: table of single-cycle vectors followed by
// hand-written door timing, re-open, reset and DONE-exit sequences.
module tb_call_request_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sensor, hall_up, hall_dn, cab;
  logic       stop;

  logic [3:0] up_req, dn_req, cab_req;
  logic [1:0] floor;
  logic       door_hold, req_above, req_below, any_req;

  logic [3:0] up_req1, dn_req1, cab_req1;
  logic [1:0] floor1;
  logic       door_hold1, req_above1, req_below1, any_req1;

  int compared   = 0;
  int mismatched = 0;

  call_request_unit #(.DOOR_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .sensor(sensor), .hall_up(hall_up), .hall_dn(hall_dn),
    .cab(cab), .stop(stop), .up_req(up_req), .dn_req(dn_req), .cab_req(cab_req),
    .floor(floor), .door_hold(door_hold), .req_above(req_above),
    .req_below(req_below), .any_req(any_req)
  );

  // Second instance exercises the shortest legal door interval on the same stimulus.
  call_request_unit #(.DOOR_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .sensor(sensor), .hall_up(hall_up), .hall_dn(hall_dn),
    .cab(cab), .stop(stop), .up_req(up_req1), .dn_req(dn_req1), .cab_req(cab_req1),
    .floor(floor1), .door_hold(door_hold1), .req_above(req_above1),
    .req_below(req_below1), .any_req(any_req1)
  );

  always #5 clk = ~clk;

  wire [17:0] obs  = {up_req, dn_req, cab_req, floor, door_hold, req_above, req_below, any_req};
  wire [16:0] obs1 = {up_req1, dn_req1, cab_req1, floor1, req_above1, req_below1, any_req1};

  typedef struct {
    logic [3:0]  sensor;
    logic [3:0]  hall_up;
    logic [3:0]  hall_dn;
    logic [3:0]  cab;
    logic        stop;
    logic [17:0] expect_out;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [17:0] ex(input logic [3:0] u, input logic [3:0] d,
                                     input logic [3:0] c, input logic [1:0] f,
                                     input logic h, input logic a, input logic b,
                                     input logic n);
    return {u, d, c, f, h, a, b, n};
  endfunction

  task automatic applyStimulus(input logic [3:0] s, input logic [3:0] hu,
                               input logic [3:0] hd, input logic [3:0] c,
                               input logic st);
    sensor  = s;
    hall_up = hu;
    hall_dn = hd;
    cab     = c;
    stop    = st;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [17:0] act,
                             input logic [17:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp_v);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp_v);
    compared++;
    if (act != exp_v) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Counts further door_hold-high samples until it drops, bounded so a stuck door ends the test.
  task automatic countHold(output int n_main, output int n_short);
    n_main  = 1;
    n_short = int'(door_hold1);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(sensor, 4'b0000, 4'b0000, 4'b0000, stop);
      n_short += int'(door_hold1);
      if (!door_hold) break;
      n_main++;
    end
  endtask

  int hold_main, hold_short;

  initial begin
    vecs[0] = '{4'b0001, 4'b0000, 4'b0000, 4'b0100, 1'b0, ex(4'b0000, 4'b0000, 4'b0100, 2'd0, 0, 1, 0, 1)};
    vecs[1] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, ex(4'b0000, 4'b0000, 4'b0100, 2'd0, 0, 1, 0, 1)};
    vecs[2] = '{4'b0001, 4'b1000, 4'b0001, 4'b0000, 1'b0, ex(4'b0000, 4'b0000, 4'b0100, 2'd0, 0, 1, 0, 1)};
    vecs[3] = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, ex(4'b0000, 4'b0010, 4'b0100, 2'd0, 0, 1, 0, 1)};
    vecs[4] = '{4'b0011, 4'b0001, 4'b0000, 4'b0000, 1'b0, ex(4'b0001, 4'b0010, 4'b0100, 2'd0, 0, 1, 0, 1)};
    vecs[5] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, ex(4'b0001, 4'b0010, 4'b0100, 2'd1, 0, 1, 1, 1)};
    vecs[6] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0, ex(4'b0001, 4'b0010, 4'b0100, 2'd3, 0, 0, 1, 1)};
    vecs[7] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, ex(4'b0001, 4'b0000, 4'b0100, 2'd1, 1, 1, 1, 1)};

    sensor = '0; hall_up = '0; hall_dn = '0; cab = '0; stop = 1'b0;
    reset = 1'b1;
    #12;
    checkOutput("reset_values", obs, 18'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].sensor, vecs[i].hall_up, vecs[i].hall_dn, vecs[i].cab, vecs[i].stop);
      checkOutput($sformatf("vec%0d", i), obs, vecs[i].expect_out);
    end

    // Reset mid-SERVING with requests pending must clear everything without a clock edge.
    sensor = '0; hall_up = '0; hall_dn = '0; cab = '0; stop = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", obs, 18'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    checkOutput("post_reset_1", obs, 18'd0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    checkOutput("post_reset_2", obs, 18'd0);

    // Service at floor 3 with the full interval on both instances.
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0100, 1'b0);
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    checkOutput("approach", obs, ex(4'b0000, 4'b0000, 4'b0100, 2'd2, 0, 0, 0, 1));
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    checkOutput("serve_entry", obs, ex(4'b0000, 4'b0000, 4'b0000, 2'd2, 1, 0, 0, 0));
    checkOutput("serve_entry_short", {1'b0, obs1}, {1'b0, 17'b0000_0000_0000_10_000});
    countHold(hold_main, hold_short);
    checkCount("door_cycles_8", hold_main, 8);
    checkCount("door_cycles_1", hold_short, 1);
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    checkOutput("done_holds", obs, ex(4'b0000, 4'b0000, 4'b0000, 2'd2, 0, 0, 0, 0));

    // Button for the current floor reopens from DONE, then again on the third SERVING cycle.
    applyStimulus(4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    checkOutput("done_reopen", obs, ex(4'b0000, 4'b0000, 4'b0000, 2'd2, 1, 0, 0, 0));
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    applyStimulus(4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    checkOutput("serving_reopen", obs, ex(4'b0000, 4'b0000, 4'b0000, 2'd2, 1, 0, 0, 0));
    countHold(hold_main, hold_short);
    checkCount("reopen_cycles", hold_main, 8);

    // Leave DONE by dropping stop, cross a sensor gap, then stop at floor 4.
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0);
    checkOutput("done_exit", obs, ex(4'b0000, 4'b0000, 4'b0100, 2'd2, 0, 0, 0, 1));
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b0);
    checkOutput("sensor_gap", obs, ex(4'b0000, 4'b0000, 4'b1100, 2'd2, 0, 1, 0, 1));
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    checkOutput("stop_between", obs, ex(4'b0000, 4'b0000, 4'b1100, 2'd2, 0, 1, 0, 1));
    applyStimulus(4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    checkOutput("arrive_floor4", obs, ex(4'b0000, 4'b0000, 4'b0100, 2'd3, 1, 0, 1, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/call_request_unit.md
# call_request_unit

Request front end for the 4-floor elevator. Latches hall and cab button presses into held request bits, tracks the last floor reported by the sensors, clears requests when the car is stopped and serving a floor, and times the door-open interval. Sits directly upstream of the elevator controller FSM: its held request vectors replace raw button levels, and `door_hold` keeps the car stopped while the door is open.

## Interface
- `DOOR_CYCLES`, 8: door-open duration in clk cycles; legal range 1..15 (4-bit counter).
- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `sensor` in 4: floor sensors, bit0 = floor 1 … bit3 = floor 4.
- `hall_up` in 4: hall up buttons, bit i = floor i+1. Bit3 is ignored.
- `hall_dn` in 4: hall down buttons. Bit0 is ignored.
- `cab` in 4: in-car floor buttons.
- `stop` in 1: controller motor-stop status.
- `up_req` out 4: held up requests; bit3 is always 0.
- `dn_req` out 4: held down requests; bit0 is always 0.
- `cab_req` out 4: held cab requests.
- `floor` out 2: last known floor, 0..3.
- `door_hold` out 1: high while the door timer runs.
- `req_above` out 1: any held request at an index greater than `floor`.
- `req_below` out 1: any held request at an index less than `floor`.
- `any_req` out 1: OR of all held request bits.

## Operation
- Reset values:
  - All request bits are 0.
  - `floor` = 0.
  - `door_hold`, `req_above`, `req_below`, `any_req` are all 0.
  - FSM in MOVING, counter 0.
- Floor tracking:
  - Registered. Priority is lowest asserted sensor (S1 first).
  - With no sensor asserted, `floor` holds its value.
  - `at_floor` = |sensor (internal).
- Request latching:
  - A button sampled high at a clk edge sets its bit.
  - A bit stays set until cleared by service; there is no cancel.
  - Buttons are level-sampled, so a held button is equivalent to a single press.
- FSM states: MOVING, SERVING, DONE.
  - MOVING → SERVING when `stop` && `at_floor`.
    - On the same edge, clear `up_req[f]`, `dn_req[f]`, `cab_req[f]`, where f = current sensor floor.
    - Load counter with DOOR_CYCLES-1.
  - SERVING: counter decrements each cycle.
    - At 0 → DONE.
    - Any button for floor f sampled high keeps bit f clear and reloads the counter (door re-open).
  - DONE → MOVING when !`stop` || !`at_floor`.
  - DONE → SERVING when a button for the current floor is sampled high. Clear and reload as on MOVING → SERVING.
  - Otherwise DONE holds.
- Simultaneous set and clear of the same bit: clear wins.
- Buttons for other floors latch normally in every state.
- `door_hold` = (state == SERVING), registered.
- `req_above`, `req_below`, `any_req`: combinational from registered request bits and `floor`.
- Reset mid-operation: all state returns to reset values asynchronously. Pending requests are lost.

## Timing
- Button high at edge N sets its bit, visible after edge N. Aggregates update in the same cycle.
- Stop at floor sampled at edge N:
  - Requests for that floor read 0 after edge N.
  - `door_hold` is high after edge N for exactly DOOR_CYCLES cycles, absent re-open.
- Re-open at edge M: `door_hold` stays high for DOOR_CYCLES cycles after edge M.
- `floor` lags `sensor` by one cycle.
- DOOR_CYCLES = 1: `door_hold` is high for one cycle.

## Structure
- Package `elevator_pkg` holds:
  - `NUM_FLOORS` = 4.
  - `floor_t` (2-bit).
  - The state enum for MOVING/SERVING/DONE.
  - The motor-state encodings shared with the controller.
- Sub-module `door_timer` contains:
  - 4-bit down-counter with `load`/`reload`.
  - `expired` output.
  - Instantiated once.
- Request registers, floor encoder, FSM and aggregates live in the top level.

## Test plan
- **Reset:** reset asserted mid-SERVING with requests pending → all outputs 0 immediately, `floor` = 0, no `door_hold` after release.
- **Latch and aggregates:** `sensor` = 0001, pulse `cab`[2] one cycle with `stop` = 0 → `cab_req` = 0100 held, `req_above` = 1, `req_below` = 0, `any_req` = 1.
- **Service at floor:** `sensor` = 0100, `stop` = 1 → `cab_req`[2] = 0 next cycle, `door_hold` high exactly 8 cycles, then DONE.
- **Re-open:** press `hall_up`[2] on cycle 3 of SERVING → bit stays 0, `door_hold` extends to 8 cycles after the press.
- **Ignored buttons and clear-wins:** press `hall_up`[3] and `hall_dn`[0] → no bits set. Press `cab`[1] at floor 2 on the MOVING → SERVING edge → `cab_req`[1] = 0.
- **Sensor gap and DONE exit:** `sensor` goes 0100 → 0000 → `floor` holds 2. Deasserting `stop` in DONE → MOVING, and later arrival at floor 4 re-enters SERVING.
